// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter: N:1 multiplexer with an internal round-robin / fixed-priority
// arbiter, a one-beat registered output slot and valid/ready handshakes on both
// sides. Sits between several producer channels and one shared consumer.
`timescale 1ns/1ps

module rr_mux_arbiter #(
    parameter  int NUM_CH = 4,
    parameter  int DATA_W = 8,
    localparam int CH_W   = $clog2(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     mode,
    input  logic [NUM_CH-1:0]        in_valid,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    output logic [NUM_CH-1:0]        in_ready,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    output logic [CH_W-1:0]          out_ch,
    input  logic                     out_ready
);

    logic [CH_W-1:0]   r_rr_ptr;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;
    logic [CH_W-1:0]   r_out_ch;

    logic              w_slot_free;
    logic              w_found;
    logic              w_transfer;
    logic [CH_W-1:0]   w_grant_ch;
    logic [CH_W-1:0]   w_next_ptr;
    logic [DATA_W-1:0] w_grant_data;
    logic [NUM_CH-1:0] w_in_ready;

    // Channel examined at step k of the round-robin search, wrapping past NUM_CH-1.
    function automatic int rotIndex(input logic [CH_W-1:0] ptr, input int k);
        int s;
        s = int'(ptr) + k;
        if (s >= NUM_CH) begin
            s = s - NUM_CH;
        end
        return s;
    endfunction

    // The slot can take a new beat when empty or being drained this cycle;
    // nothing is granted while reset is held.
    assign w_slot_free = !rst && (!r_out_valid || out_ready);
    assign w_transfer  = w_slot_free && w_found;

    // Arbitration: fixed priority scans from channel 0, round-robin scans from r_rr_ptr.
    always_comb begin
        w_found    = 1'b0;
        w_grant_ch = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (mode) begin
                if (!w_found && in_valid[CH_W'(k)]) begin
                    w_found    = 1'b1;
                    w_grant_ch = CH_W'(k);
                end
            end else begin
                if (!w_found && in_valid[CH_W'(rotIndex(r_rr_ptr, k))]) begin
                    w_found    = 1'b1;
                    w_grant_ch = CH_W'(rotIndex(r_rr_ptr, k));
                end
            end
        end
    end

    // Data mux for the granted channel and the one-hot grant back to producers.
    always_comb begin
        w_grant_data = '0;
        w_in_ready   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_grant_ch == CH_W'(i)) begin
                w_grant_data  = in_data[i*DATA_W +: DATA_W];
                w_in_ready[i] = w_transfer;
            end
        end
    end

    // Pointer moves to the channel after the winner in both modes, wrapping to 0.
    assign w_next_ptr = (w_grant_ch == CH_W'(NUM_CH - 1)) ? '0 : w_grant_ch + CH_W'(1);

    // Output slot: load on a grant, empty when free with no request, hold while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_ch    <= '0;
            r_rr_ptr    <= '0;
        end else if (w_slot_free) begin
            if (w_transfer) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_grant_data;
                r_out_ch    <= w_grant_ch;
                r_rr_ptr    <= w_next_ptr;
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_ch    = r_out_ch;

endmodule
